// File: rtl/pipe_mem_wb_elastic_if.sv
// Handshake/bus bundle for the MEM->WB elastic stage.
// Forwarding signals exist only when PIPE_MEM_WB_ELASTIC_FWD_EN is defined.
interface pipe_mem_wb_elastic_if #(
    parameter int DATAPATH_WIDTH     = 64,
    parameter int REGFILE_ADDR_WIDTH = 5
);
    logic                          in_valid;
    logic                          in_ready;
    logic [DATAPATH_WIDTH-1:0]     mem_data_in;
    logic [DATAPATH_WIDTH-1:0]     accum_in;
    logic                          wb_sel_in;
    logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_in;
    logic                          WR_en_in;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATAPATH_WIDTH-1:0]     wb_data_out;
    logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_out;
    logic                          WR_en_out;
`ifdef PIPE_MEM_WB_ELASTIC_FWD_EN
    logic                          fwd_valid;
    logic [REGFILE_ADDR_WIDTH-1:0] fwd_addr;
    logic [DATAPATH_WIDTH-1:0]     fwd_data;
`endif

    modport master (
        output in_valid, mem_data_in, accum_in, wb_sel_in, WR_addr_in, WR_en_in, out_ready,
`ifdef PIPE_MEM_WB_ELASTIC_FWD_EN
        input  fwd_valid, fwd_addr, fwd_data,
`endif
        input  in_ready, out_valid, wb_data_out, WR_addr_out, WR_en_out
    );

    modport slave (
        input  in_valid, mem_data_in, accum_in, wb_sel_in, WR_addr_in, WR_en_in, out_ready,
`ifdef PIPE_MEM_WB_ELASTIC_FWD_EN
        output fwd_valid, fwd_addr, fwd_data,
`endif
        output in_ready, out_valid, wb_data_out, WR_addr_out, WR_en_out
    );
endinterface

// File: rtl/pipe_mem_wb_elastic.sv
// Two-entry (head + skid) elastic MEM->WB pipeline stage with registered in_ready.
// Optional forwarding outputs enabled by defining PIPE_MEM_WB_ELASTIC_FWD_EN.
module pipe_mem_wb_elastic #(
    parameter int DATAPATH_WIDTH     = 64,
    parameter int REGFILE_ADDR_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    pipe_mem_wb_elastic_if.slave bus
);
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic                          r_in_ready;
    logic [DATAPATH_WIDTH-1:0]     r_head_data;
    logic [REGFILE_ADDR_WIDTH-1:0] r_head_addr;
    logic                          r_head_en;
    logic [DATAPATH_WIDTH-1:0]     r_skid_data;
    logic [REGFILE_ADDR_WIDTH-1:0] r_skid_addr;
    logic                          r_skid_en;

    logic                          w_out_valid;
    logic                          w_accept;
    logic                          w_pop;
    logic [DATAPATH_WIDTH-1:0]     w_in_data;
    logic                          w_load_head_in;
    logic                          w_load_head_skid;
    logic                          w_load_skid;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = bus.in_valid && r_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_in_data   = bus.wb_sel_in ? bus.mem_data_in : bus.accum_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = ST_ONE;
                        w_load_head_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        w_load_head_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_state_nxt      = ST_ONE;
                        w_load_head_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Head is cleared on flush so a flushed stage presents all-zero outputs.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_head_data <= '0;
            r_head_addr <= '0;
            r_head_en   <= 1'b0;
            r_skid_data <= '0;
            r_skid_addr <= '0;
            r_skid_en   <= 1'b0;
        end else begin
            if (w_load_head_in) begin
                r_head_data <= w_in_data;
                r_head_addr <= bus.WR_addr_in;
                r_head_en   <= bus.WR_en_in;
            end else if (w_load_head_skid) begin
                r_head_data <= r_skid_data;
                r_head_addr <= r_skid_addr;
                r_head_en   <= r_skid_en;
            end
            if (w_load_skid) begin
                r_skid_data <= w_in_data;
                r_skid_addr <= bus.WR_addr_in;
                r_skid_en   <= bus.WR_en_in;
            end
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.wb_data_out = r_head_data;
    assign bus.WR_addr_out = r_head_addr;
    assign bus.WR_en_out   = r_head_en && w_out_valid;

`ifdef PIPE_MEM_WB_ELASTIC_FWD_EN
    logic w_skid_fwd;

    // Youngest enabled entry wins: skid when occupied and enabled, else head.
    assign w_skid_fwd    = (r_state == ST_FULL) && r_skid_en;
    assign bus.fwd_valid = w_skid_fwd || (w_out_valid && r_head_en);
    assign bus.fwd_addr  = w_skid_fwd ? r_skid_addr : r_head_addr;
    assign bus.fwd_data  = w_skid_fwd ? r_skid_data : r_head_data;
`endif
endmodule

// File: tb/tb_pipe_mem_wb_elastic.sv
// Directed self-checking bench for pipe_mem_wb_elastic (default and FWD_EN builds).
module tb_pipe_mem_wb_elastic;
    logic clk;
    logic reset;
    logic flush;
    int   total;
    int   bad;

    pipe_mem_wb_elastic_if #(.DATAPATH_WIDTH(64), .REGFILE_ADDR_WIDTH(5)) bus ();

    pipe_mem_wb_elastic #(.DATAPATH_WIDTH(64), .REGFILE_ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct packed {
        logic [63:0] d;
        logic [4:0]  a;
        logic        e;
    } entry_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic sel, input logic [63:0] mem,
                         input logic [63:0] acc, input logic [4:0] addr, input logic en);
        bus.in_valid    = v;
        bus.wb_sel_in   = sel;
        bus.mem_data_in = mem;
        bus.accum_in    = acc;
        bus.WR_addr_in  = addr;
        bus.WR_en_in    = en;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        cycle();
        cycle();
        total += 5;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", bus.in_ready); end
        if (bus.wb_data_out !== 64'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", bus.wb_data_out); end
        if (bus.WR_addr_out !== 5'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", bus.WR_addr_out); end
        if (bus.WR_en_out !== 1'b0) begin bad++; $display("FAIL rst_en got=%0b exp=0", bus.WR_en_out); end
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b0, 64'hDEAD, 64'h11, 5'd3, 1'b1);
        cycle();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        total += 5;
        if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", bus.out_valid); end
        if (bus.wb_data_out !== 64'h11) begin bad++; $display("FAIL single_data got=%h exp=11", bus.wb_data_out); end
        if (bus.WR_addr_out !== 5'd3) begin bad++; $display("FAIL single_addr got=%0d exp=3", bus.WR_addr_out); end
        if (bus.WR_en_out !== 1'b1) begin bad++; $display("FAIL single_en got=%0b exp=1", bus.WR_en_out); end
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%0b exp=1", bus.in_ready); end
        cycle();
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_skid();
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b1, 64'hAA, 64'h1234, 5'd1, 1'b1);
        cycle();
        total += 3;
        if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL skid_a_valid got=%0b exp=1", bus.out_valid); end
        if (bus.wb_data_out !== 64'hAA) begin bad++; $display("FAIL skid_a_data got=%h exp=aa", bus.wb_data_out); end
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL skid_a_ready got=%0b exp=1", bus.in_ready); end
        drive(1'b1, 1'b0, 64'h5555, 64'hBB, 5'd2, 1'b0);
        cycle();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        total += 3;
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL skid_full_ready got=%0b exp=0", bus.in_ready); end
        if (bus.wb_data_out !== 64'hAA) begin bad++; $display("FAIL skid_hold_data got=%h exp=aa", bus.wb_data_out); end
        if (bus.WR_addr_out !== 5'd1) begin bad++; $display("FAIL skid_hold_addr got=%0d exp=1", bus.WR_addr_out); end
        cycle();
        total += 2;
        if (bus.wb_data_out !== 64'hAA) begin bad++; $display("FAIL skid_stall_data got=%h exp=aa", bus.wb_data_out); end
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL skid_stall_ready got=%0b exp=0", bus.in_ready); end
        bus.out_ready = 1'b1;
        cycle();
        total += 5;
        if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL skid_b_valid got=%0b exp=1", bus.out_valid); end
        if (bus.wb_data_out !== 64'hBB) begin bad++; $display("FAIL skid_b_data got=%h exp=bb", bus.wb_data_out); end
        if (bus.WR_addr_out !== 5'd2) begin bad++; $display("FAIL skid_b_addr got=%0d exp=2", bus.WR_addr_out); end
        if (bus.WR_en_out !== 1'b0) begin bad++; $display("FAIL skid_b_en got=%0b exp=0", bus.WR_en_out); end
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL skid_b_ready got=%0b exp=1", bus.in_ready); end
        cycle();
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL skid_drain got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_stream();
        entry_t      q[$];
        entry_t      exp_e;
        entry_t      held;
        logic        stalled;
        logic        acc;
        logic        pop;
        int          sent = 0;
        int          rcvd = 0;
        int          cyc  = 0;
        logic [63:0] mv;
        logic [63:0] av;
        logic        sel;
        while (rcvd < 100 && cyc < 3000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            mv  = 64'h1000_0000_0000_0000 + 64'(sent * 7);
            av  = 64'h0000_0000_ABC0_0000 + 64'(sent * 13);
            sel = sent[0];
            drive((sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0, sel, mv, av,
                  5'(sent), (sent % 3) != 0);
            acc = bus.in_valid && bus.in_ready;
            pop = bus.out_valid && bus.out_ready;
            if (pop) begin
                exp_e = q.pop_front();
                total++;
                if (bus.wb_data_out !== exp_e.d || bus.WR_addr_out !== exp_e.a || bus.WR_en_out !== exp_e.e) begin
                    bad++;
                    $display("FAIL stream_order n=%0d got=%h/%0d/%0b exp=%h/%0d/%0b", rcvd,
                             bus.wb_data_out, bus.WR_addr_out, bus.WR_en_out, exp_e.d, exp_e.a, exp_e.e);
                end
                rcvd++;
            end
            if (acc) begin
                q.push_back({sel ? mv : av, 5'(sent), (sent % 3) != 0});
                sent++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = {bus.wb_data_out, bus.WR_addr_out, bus.WR_en_out};
            cycle();
            cyc++;
            if (stalled) begin
                total++;
                if ({bus.out_valid, bus.wb_data_out, bus.WR_addr_out, bus.WR_en_out} !== {1'b1, held}) begin
                    bad++;
                    $display("FAIL stream_stall_stable got=%h/%0d/%0b exp=%h/%0d/%0b", bus.wb_data_out,
                             bus.WR_addr_out, bus.WR_en_out, held.d, held.a, held.e);
                end
            end
        end
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        bus.out_ready = 1'b1;
        total++;
        if (rcvd != 100 || q.size() != 0) begin
            bad++;
            $display("FAIL stream_count got=%0d left=%0d exp=100 left=0", rcvd, q.size());
        end
        cycle();
        cycle();
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b0, '0, 64'hA1, 5'd5, 1'b1);
        cycle();
        drive(1'b1, 1'b0, '0, 64'hB2, 5'd6, 1'b1);
        cycle();
        drive(1'b1, 1'b0, '0, 64'hC3, 5'd7, 1'b1);
        total++;
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_pre_full got=%0b exp=0", bus.in_ready); end
        flush = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        total += 3;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%0b exp=1", bus.in_ready); end
        if (bus.WR_en_out !== 1'b0) begin bad++; $display("FAIL flush_en got=%0b exp=0", bus.WR_en_out); end
`ifdef PIPE_MEM_WB_ELASTIC_FWD_EN
        total++;
        if (bus.fwd_valid !== 1'b0) begin bad++; $display("FAIL flush_fwd got=%0b exp=0", bus.fwd_valid); end
`endif
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost i=%0d got=%0b exp=0", i, bus.out_valid); end
        end
    endtask

    task automatic test_reset_full();
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b1, 64'hF1, '0, 5'd9, 1'b1);
        cycle();
        drive(1'b1, 1'b1, 64'hF2, '0, 5'd10, 1'b1);
        cycle();
        reset = 1'b1;
        flush = 1'b1;
        cycle();
        total += 5;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstfull_valid got=%0b exp=0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstfull_ready got=%0b exp=1", bus.in_ready); end
        if (bus.wb_data_out !== 64'h0) begin bad++; $display("FAIL rstfull_data got=%h exp=0", bus.wb_data_out); end
        if (bus.WR_addr_out !== 5'd0) begin bad++; $display("FAIL rstfull_addr got=%0d exp=0", bus.WR_addr_out); end
        if (bus.WR_en_out !== 1'b0) begin bad++; $display("FAIL rstfull_en got=%0b exp=0", bus.WR_en_out); end
`ifdef PIPE_MEM_WB_ELASTIC_FWD_EN
        total++;
        if (bus.fwd_valid !== 1'b0) begin bad++; $display("FAIL rstfull_fwd got=%0b exp=0", bus.fwd_valid); end
`endif
        reset = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b0, '0, 64'h5A, 5'd12, 1'b1);
        cycle();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        total += 3;
        if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL postrst_valid got=%0b exp=1", bus.out_valid); end
        if (bus.wb_data_out !== 64'h5A) begin bad++; $display("FAIL postrst_data got=%h exp=5a", bus.wb_data_out); end
        if (bus.WR_addr_out !== 5'd12) begin bad++; $display("FAIL postrst_addr got=%0d exp=12", bus.WR_addr_out); end
        cycle();
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL postrst_drain got=%0b exp=0", bus.out_valid); end
    endtask

`ifdef PIPE_MEM_WB_ELASTIC_FWD_EN
    task automatic test_fwd();
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b0, '0, 64'h44, 5'd4, 1'b1);
        cycle();
        drive(1'b1, 1'b0, '0, 64'h77, 5'd7, 1'b0);
        cycle();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        total += 3;
        if (bus.fwd_valid !== 1'b1) begin bad++; $display("FAIL fwd_valid got=%0b exp=1", bus.fwd_valid); end
        if (bus.fwd_addr !== 5'd4) begin bad++; $display("FAIL fwd_addr got=%0d exp=4", bus.fwd_addr); end
        if (bus.fwd_data !== 64'h44) begin bad++; $display("FAIL fwd_data got=%h exp=44", bus.fwd_data); end
        bus.out_ready = 1'b1;
        cycle();
        total++;
        if (bus.fwd_valid !== 1'b0) begin bad++; $display("FAIL fwd_bubble got=%0b exp=0", bus.fwd_valid); end
        cycle();
        drive(1'b1, 1'b0, '0, 64'h81, 5'd8, 1'b1);
        bus.out_ready = 1'b0;
        cycle();
        drive(1'b1, 1'b0, '0, 64'h92, 5'd9, 1'b1);
        cycle();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        total += 2;
        if (bus.fwd_addr !== 5'd9) begin bad++; $display("FAIL fwd_skid_addr got=%0d exp=9", bus.fwd_addr); end
        if (bus.fwd_data !== 64'h92) begin bad++; $display("FAIL fwd_skid_data got=%h exp=92", bus.fwd_data); end
        bus.out_ready = 1'b1;
        cycle();
        cycle();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_skid();
        test_stream();
        test_flush();
        test_reset_full();
`ifdef PIPE_MEM_WB_ELASTIC_FWD_EN
        test_fwd();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_mem_wb_elastic.md
PIPE_MEM_WB_ELASTIC -- requirements
Module: pipe_mem_wb_elastic

Interface
REQ-001 Parameter DATAPATH_WIDTH, default 64, width of the memory-data, accumulator and write-back data paths.
REQ-002 Parameter REGFILE_ADDR_WIDTH, default 5, width of the register-file write address.
REQ-003 clk  in  1  clock; all state SHALL update on the rising edge only.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 flush  in  1  discard all held entries; synchronous.
REQ-006 in_valid  in  1  upstream entry present.
REQ-007 in_ready  out  1  stage can accept; registered, not combinationally derived from out_ready.
REQ-008 mem_data_in  in  DATAPATH_WIDTH  load data.
REQ-009 accum_in  in  DATAPATH_WIDTH  ALU/accumulator result.
REQ-010 wb_sel_in  in  1  1 = write back mem_data_in, 0 = write back accum_in.
REQ-011 WR_addr_in  in  REGFILE_ADDR_WIDTH  destination register.
REQ-012 WR_en_in  in  1  register write request.
REQ-013 out_valid  out  1  output entry present.
REQ-014 out_ready  in  1  downstream (write-back) accepts.
REQ-015 wb_data_out  out  DATAPATH_WIDTH  selected write-back data.
REQ-016 WR_addr_out  out  REGFILE_ADDR_WIDTH  destination register of the head entry.
REQ-017 WR_en_out  out  1  equals head WR_en AND out_valid.

Function
REQ-018 Storage SHALL be two entries: head (drives outputs) and skid; each holds {wb_data, WR_addr, WR_en}, with wb_data muxed on entry by wb_sel_in.
REQ-019 State machine SHALL have three states: EMPTY (no entries), ONE (head only), FULL (head and skid).
REQ-020 Accept SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-021 EMPTY: accept -> ONE, entry written to head; latency from accept to out_valid is exactly 1 cycle.
REQ-022 ONE: accept and pop -> ONE, head replaced; accept only -> FULL, entry written to skid; pop only -> EMPTY.
REQ-023 FULL: pop -> ONE, skid moves to head; in_valid is ignored because in_ready=0.
REQ-024 in_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL.
REQ-025 Stall: while out_valid && !out_ready, all outputs SHALL hold stable.
REQ-026 Ordering: entries SHALL leave in acceptance order; no entry is dropped or duplicated except on flush or reset.
REQ-027 flush SHALL take priority over accept and pop in the same cycle; the next state is EMPTY and in_ready=1.
REQ-028 An entry offered in the flush cycle SHALL be discarded.
REQ-029 Entries with WR_en_in=0 SHALL still flow as bubbles-with-valid, so ordering is preserved.

Reset
REQ-030 While reset is high: state EMPTY, out_valid=0, in_ready=1, wb_data_out=0, WR_addr_out=0, WR_en_out=0, skid contents=0.
REQ-031 Reset SHALL override flush and any handshake, including mid-FULL.
REQ-032 After reset deasserts, the first accept SHALL behave as in EMPTY.

Configuration
REQ-033 Macro PIPE_MEM_WB_ELASTIC_FWD_EN, when defined, SHALL add outputs fwd_valid (1), fwd_addr (REGFILE_ADDR_WIDTH) and fwd_data (DATAPATH_WIDTH), all reflecting the youngest held entry with WR_en=1 (skid if occupied and enabled, else head).
REQ-034 With PIPE_MEM_WB_ELASTIC_FWD_EN defined, fwd_valid SHALL be 0 in EMPTY, after flush and during reset.
REQ-035 Without PIPE_MEM_WB_ELASTIC_FWD_EN, the three fwd ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Reset then in_valid=1, accum_in=0x11, wb_sel_in=0, WR_addr_in=3, WR_en_in=1, out_ready=1 -> next cycle out_valid=1, wb_data_out=0x11, WR_addr_out=3, WR_en_out=1.
REQ-037 out_ready=0, accept A (mem=0xAA, sel=1) then B (accum=0xBB) -> in_ready=0 after B; raise out_ready -> outputs AA then BB on consecutive cycles, in_ready back to 1.
REQ-038 Stream 100 entries with random out_ready -> outputs in order, none lost, outputs stable on every stalled cycle.
REQ-039 FULL with a pending in_valid, assert flush for 1 cycle -> next cycle out_valid=0, in_ready=1, WR_en_out=0; the pending entry never appears.
REQ-040 Assert reset while FULL and out_ready=0 -> next cycle all outputs 0 and in_ready=1; with FWD_EN defined, fwd_valid=0.
REQ-041 With FWD_EN defined: head WR_addr=4 (WR_en=1), skid WR_addr=7 (WR_en=0) -> fwd_addr=4, fwd_valid=1.
